// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge: AXI4 master bridge for the D-cache miss path.
// Line refills become INCR read bursts streamed back to the cache; dirty victims are
// latched into a line buffer and written out as INCR write bursts. Read and write
// sides are independent FSMs with one outstanding request each.
// Optional feature macro: DCACHE_AXI_ERR_CAPTURE_EN adds sticky axi_err[2:0]
// {rlast_mismatch, bresp_err, rresp_err}.
module dcache_axi_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_BYTES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      r_req,
    input  logic [ADDR_WIDTH-1:0]     r_addr,
    output logic                      r_rdy,
    output logic [DATA_WIDTH-1:0]     r_data,
    output logic                      r_data_valid,
    input  logic                      r_data_ready,
    output logic                      r_last,
    input  logic                      w_req,
    input  logic [ADDR_WIDTH-1:0]     w_addr,
    input  logic [LINE_BYTES*8-1:0]   w_data,
    output logic                      w_rdy,
    output logic                      wrt_finish,
    output logic [ADDR_WIDTH-1:0]     araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready,
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
`ifdef DCACHE_AXI_ERR_CAPTURE_EN
    ,
    output logic [2:0]                axi_err
`endif
);

    localparam int BEATS  = LINE_BYTES * 8 / DATA_WIDTH;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [7:0]       AX_LEN    = 8'(BEATS - 1);
    localparam logic [2:0]       AX_SIZE   = 3'($clog2(DATA_WIDTH / 8));

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_AR   = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_AW   = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    logic [1:0]            r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [CNT_W-1:0]      rcnt_q, rcnt_d;
    logic [1:0]            w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [LINE_W-1:0]     wbuf_q, wbuf_d;
    logic [CNT_W-1:0]      wcnt_q, wcnt_d;
    logic                  hazard_s;

    // Burst shape constants and registered payloads; the write buffer shifts so beat 0 is always at the bottom.
    assign araddr     = raddr_q;
    assign arlen      = AX_LEN;
    assign arsize     = AX_SIZE;
    assign arburst    = 2'b01;
    assign awaddr     = waddr_q;
    assign awlen      = AX_LEN;
    assign awsize     = AX_SIZE;
    assign awburst    = 2'b01;
    assign wstrb      = {(DATA_WIDTH/8){1'b1}};
    assign wdata      = wbuf_q[DATA_WIDTH-1:0];
    assign r_data     = rdata;
    assign wrt_finish = (w_state_q == W_IDLE);

    // Read-after-write hazard: a refill must not overtake a writeback of the same line.
    always_comb begin
        hazard_s = 1'b0;
        if (w_state_q != W_IDLE) begin
            hazard_s = (r_addr[ADDR_WIDTH-1:OFF_W] == waddr_q[ADDR_WIDTH-1:OFF_W]);
        end else begin
            hazard_s = w_req && (r_addr[ADDR_WIDTH-1:OFF_W] == w_addr[ADDR_WIDTH-1:OFF_W]);
        end
    end

    // Read FSM next state and cache/AXI read handshakes.
    always_comb begin
        r_state_d    = r_state_q;
        raddr_d      = raddr_q;
        rcnt_d       = rcnt_q;
        r_rdy        = 1'b0;
        arvalid      = 1'b0;
        r_data_valid = 1'b0;
        rready       = 1'b0;
        r_last       = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (r_req && !hazard_s && !rst) begin
                    r_rdy     = 1'b1;
                    raddr_d   = {r_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    r_state_d = R_AR;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    r_state_d = R_DATA;
                    rcnt_d    = {CNT_W{1'b0}};
                end else begin
                    r_state_d = R_AR;
                end
            end
            R_DATA: begin
                r_data_valid = rvalid;
                rready       = r_data_ready;
                r_last       = rvalid && (rcnt_q == LAST_BEAT);
                if (rvalid && r_data_ready) begin
                    rcnt_d = rcnt_q + CNT_W'(1);
                    if (rcnt_q == LAST_BEAT) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_state_d = R_DATA;
                    end
                end else begin
                    rcnt_d = rcnt_q;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Write FSM next state, victim line capture and AXI write handshakes.
    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wbuf_d    = wbuf_q;
        wcnt_d    = wcnt_q;
        w_rdy     = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        bready    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (w_req && !rst) begin
                    w_rdy     = 1'b1;
                    waddr_d   = {w_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    wbuf_d    = w_data;
                    w_state_d = W_AW;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    w_state_d = W_DATA;
                    wcnt_d    = {CNT_W{1'b0}};
                end else begin
                    w_state_d = W_AW;
                end
            end
            W_DATA: begin
                wvalid = 1'b1;
                wlast  = (wcnt_q == LAST_BEAT);
                if (wready) begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                    wbuf_d = wbuf_q >> DATA_WIDTH;
                    if (wcnt_q == LAST_BEAT) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_state_d = W_DATA;
                    end
                end else begin
                    wcnt_d = wcnt_q;
                end
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            raddr_q   <= {ADDR_WIDTH{1'b0}};
            rcnt_q    <= {CNT_W{1'b0}};
            w_state_q <= W_IDLE;
            waddr_q   <= {ADDR_WIDTH{1'b0}};
            wbuf_q    <= {LINE_W{1'b0}};
            wcnt_q    <= {CNT_W{1'b0}};
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rcnt_q    <= rcnt_d;
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wbuf_q    <= wbuf_d;
            wcnt_q    <= wcnt_d;
        end
    end

`ifdef DCACHE_AXI_ERR_CAPTURE_EN
    logic [2:0] axi_err_q, axi_err_d;
    logic       unused_s;

    assign axi_err  = axi_err_q;
    assign unused_s = ^{r_addr[OFF_W-1:0], w_addr[OFF_W-1:0]};

    // Sticky error capture: bad read/write responses and rlast disagreeing with the beat count.
    always_comb begin
        axi_err_d = axi_err_q;
        if ((r_state_q == R_DATA) && rvalid && r_data_ready) begin
            if (rresp != 2'b00) begin
                axi_err_d[0] = 1'b1;
            end else begin
                axi_err_d[0] = axi_err_q[0];
            end
            if (rlast != (rcnt_q == LAST_BEAT)) begin
                axi_err_d[2] = 1'b1;
            end else begin
                axi_err_d[2] = axi_err_q[2];
            end
        end else begin
            axi_err_d = axi_err_q;
        end
        if ((w_state_q == W_RESP) && bvalid && (bresp != 2'b00)) begin
            axi_err_d[1] = 1'b1;
        end else begin
            axi_err_d[1] = axi_err_q[1];
        end
    end

    // Error flags clear only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            axi_err_q <= 3'b000;
        end else begin
            axi_err_q <= axi_err_d;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{r_addr[OFF_W-1:0], w_addr[OFF_W-1:0], rresp, rlast, bresp};
`endif

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Self-checking bench for dcache_axi_bridge: AXI slave models and a cache-side consumer
// run in the background, expectations are queued when requests are issued.
`timescale 1ns/1ps
module tb_dcache_axi_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LB = 64;
    localparam int NB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r_req = 1'b0, r_rdy, r_data_valid, r_data_ready = 1'b1, r_last;
    logic [AW-1:0] r_addr = '0, w_addr = '0, araddr, awaddr;
    logic [DW-1:0] r_data, rdata = '0, wdata;
    logic w_req = 1'b0, w_rdy, wrt_finish;
    logic [LB*8-1:0] w_data = '0;
    logic [7:0] arlen, awlen;
    logic [2:0] arsize, awsize;
    logic [1:0] arburst, awburst, rresp = 2'b00, bresp = 2'b00;
    logic arvalid, arready = 1'b0, rlast = 1'b0, rvalid = 1'b0, rready;
    logic awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
    logic [DW/8-1:0] wstrb;
`ifdef DCACHE_AXI_ERR_CAPTURE_EN
    logic [2:0] axi_err;
`endif

    dcache_axi_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_BYTES(LB)) dut (
        .clk(clk), .rst(rst),
        .r_req(r_req), .r_addr(r_addr), .r_rdy(r_rdy), .r_data(r_data),
        .r_data_valid(r_data_valid), .r_data_ready(r_data_ready), .r_last(r_last),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_rdy(w_rdy), .wrt_finish(wrt_finish),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef DCACHE_AXI_ERR_CAPTURE_EN
        , .axi_err(axi_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard queues
    logic [31:0] exp_ar[$], exp_aw[$], exp_r[$], exp_w[$], rb_q[$];
    logic        exp_rl[$], exp_wl[$];

    // stimulus knobs and progress counters
    bit rdy_toggle = 1'b0, rgap_en = 1'b0, stall_en = 1'b0, w_hold = 1'b0;
    bit bresp_err = 1'b0, inj_rlast = 1'b0;
    int b_delay = 1;
    int beats_rx = 0;
    int b_done = 0;

    // read slave state
    bit rd_act = 1'b0;
    int rd_beat = 0;
    logic [31:0] rd_base = '0;

    // AXI read slave: AR always ready, R beats base+i with optional gaps
    always @(negedge clk) begin
        arready = 1'b1;
        rvalid  = rd_act && !(rgap_en && ($urandom_range(0, 2) == 0));
        rdata   = rd_base + 32'(rd_beat);
        rlast   = (rd_beat == NB - 1) || (inj_rlast && rd_beat == 10);
        rresp   = 2'b00;
        #1;
        if (rst) begin
            rd_act = 1'b0;
            rd_beat = 0;
        end else if (arvalid && arready) begin
            if (exp_ar.size() == 0) begin
                chk("ar_unexpected", 64'd1, 64'd0);
            end else begin
                chk("araddr", araddr, exp_ar.pop_front());
                chk("arlen", arlen, 64'd15);
                chk("arsize_burst", {arsize, arburst}, {3'd2, 2'b01});
                rd_base = rb_q.pop_front();
            end
            rd_act = 1'b1;
            rd_beat = 0;
        end else if (rd_act && rvalid && rready) begin
            rd_beat++;
            if (rd_beat == NB) rd_act = 1'b0;
        end
    end

    // cache-side consumer of refill beats
    always @(negedge clk) begin
        r_data_ready = rdy_toggle ? ~r_data_ready : 1'b1;
        #1;
        if (!rst && r_data_valid && r_data_ready) begin
            if (exp_r.size() == 0) begin
                chk("r_unexpected", 64'd1, 64'd0);
            end else begin
                chk("r_data", r_data, exp_r.pop_front());
                chk("r_last", r_last, exp_rl.pop_front());
            end
            beats_rx++;
        end
    end

    // write slave state
    int w_beat = 0, w_stall = 0, b_wait = 0;
    bit b_pend = 1'b0;

    // AXI write slave: optional 3-cycle stall at beat 8, B after b_delay cycles
    always @(negedge clk) begin
        awready = 1'b1;
        wready  = !w_hold && !(stall_en && w_beat == 8 && w_stall < 3);
        bvalid  = b_pend && (b_wait >= b_delay);
        bresp   = bresp_err ? 2'b10 : 2'b00;
        #1;
        if (rst) begin
            w_beat = 0; w_stall = 0; b_pend = 1'b0; b_wait = 0;
        end else begin
            if (awvalid && awready) begin
                if (exp_aw.size() == 0) begin
                    chk("aw_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("awaddr", awaddr, exp_aw.pop_front());
                    chk("awlen", awlen, 64'd15);
                    chk("awsize_burst", {awsize, awburst}, {3'd2, 2'b01});
                end
            end
            if (wvalid && wready) begin
                if (exp_w.size() == 0) begin
                    chk("w_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("wdata", wdata, exp_w.pop_front());
                    chk("wlast", wlast, exp_wl.pop_front());
                    chk("wstrb", wstrb, 64'hF);
                end
                w_beat++;
                if (w_beat == NB) begin
                    w_beat = 0; w_stall = 0; b_pend = 1'b1; b_wait = 0;
                end
            end else if (wvalid && w_beat == 8) begin
                w_stall++;
            end
            if (bvalid && bready) begin
                chk("wrt_finish_in_resp", wrt_finish, 64'd0);
                b_pend = 1'b0;
                b_done++;
            end else if (b_pend) begin
                b_wait++;
            end
        end
    end

    task automatic rd_push(input logic [31:0] a, input logic [31:0] base);
        exp_ar.push_back({a[31:6], 6'b0});
        rb_q.push_back(base);
        for (int i = 0; i < NB; i++) begin
            exp_r.push_back(base + 32'(i));
            exp_rl.push_back(i == NB - 1);
        end
    endtask

    task automatic wr_push(input logic [31:0] a, input logic [31:0] base);
        exp_aw.push_back({a[31:6], 6'b0});
        w_addr = a;
        for (int i = 0; i < NB; i++) begin
            w_data[i*32 +: 32] = base + 32'(i);
            exp_w.push_back(base + 32'(i));
            exp_wl.push_back(i == NB - 1);
        end
    endtask

    // called at a negedge with r_req already raised
    task automatic rd_wait(output logic wf_acc, output logic wf_prev);
        int n;
        logic prev;
        n = 0;
        prev = 1'b1;
        #1;
        while (!r_rdy && n < 400) begin
            prev = wrt_finish;
            @(negedge clk); #1;
            n++;
        end
        chk("r_rdy_seen", r_rdy, 64'd1);
        wf_acc = wrt_finish;
        wf_prev = prev;
        @(negedge clk); #1;
        chk("r_rdy_pulse", r_rdy, 64'd0);
        r_req = 1'b0;
    endtask

    // called at a negedge with w_req already raised
    task automatic wr_wait();
        int n;
        n = 0;
        #1;
        while (!w_rdy && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        chk("w_rdy_seen", w_rdy, 64'd1);
        @(negedge clk); #1;
        chk("w_rdy_pulse", w_rdy, 64'd0);
        chk("wrt_finish_fall", wrt_finish, 64'd0);
        w_req = 1'b0;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        @(negedge clk); #2;
        while (!(exp_r.size() == 0 && exp_w.size() == 0 && exp_ar.size() == 0 && wrt_finish) && n < 800) begin
            @(negedge clk); #2;
            n++;
        end
        chk("quiet_timeout", n < 800, 64'd1);
        @(negedge clk); #2;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int n;
        logic acc, prev;

        // reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_r_rdy", r_rdy, 64'd0);
        chk("rst_r_data_valid", r_data_valid, 64'd0);
        chk("rst_r_last", r_last, 64'd0);
        chk("rst_w_rdy", w_rdy, 64'd0);
        chk("rst_arvalid", arvalid, 64'd0);
        chk("rst_rready", rready, 64'd0);
        chk("rst_awvalid", awvalid, 64'd0);
        chk("rst_wvalid", wvalid, 64'd0);
        chk("rst_wlast", wlast, 64'd0);
        chk("rst_bready", bready, 64'd0);
        chk("rst_wrt_finish", wrt_finish, 64'd1);

        // 1: basic refill, unaligned address
        b0 = beats_rx;
        rd_push(32'h1000_0024, 32'h0);
        @(negedge clk); r_req = 1'b1; r_addr = 32'h1000_0024;
        rd_wait(acc, prev);
        wait_quiet();
        chk("t1_beats", beats_rx - b0, 64'd16);
        chk("t1_idle_valid", r_data_valid, 64'd0);
        chk("t1_idle_arvalid", arvalid, 64'd0);

        // 2: ready toggling and rvalid gaps
        rdy_toggle = 1'b1; rgap_en = 1'b1;
        b0 = beats_rx;
        rd_push(32'h1000_0100, 32'h100);
        @(negedge clk); r_req = 1'b1; r_addr = 32'h1000_0100;
        rd_wait(acc, prev);
        wait_quiet();
        chk("t2_beats", beats_rx - b0, 64'd16);
        rdy_toggle = 1'b0; rgap_en = 1'b0;

        // 3: writeback with mid-burst stall and late B
        stall_en = 1'b1; b_delay = 5;
        b0 = b_done;
        wr_push(32'h2000_0040, 32'hA0);
        @(negedge clk); w_req = 1'b1;
        wr_wait();
        wait_quiet();
        chk("t3_bdone", b_done - b0, 64'd1);
        chk("t3_wrt_finish", wrt_finish, 64'd1);
        stall_en = 1'b0; b_delay = 1;

        // 4a: read to the line being written back waits for B
        wr_push(32'h3000_0000, 32'h300);
        @(negedge clk); w_req = 1'b1;
        wr_wait();
        rd_push(32'h3000_0000, 32'h400);
        @(negedge clk); r_req = 1'b1; r_addr = 32'h3000_0000;
        rd_wait(acc, prev);
        chk("t4a_acc_after_b", acc, 64'd1);
        chk("t4a_first_idle", prev, 64'd0);
        wait_quiet();

        // 4b: different line proceeds during writeback
        b_delay = 8;
        wr_push(32'h3000_0000, 32'h500);
        @(negedge clk); w_req = 1'b1;
        wr_wait();
        rd_push(32'h3000_0040, 32'h600);
        @(negedge clk); r_req = 1'b1; r_addr = 32'h3000_0040;
        rd_wait(acc, prev);
        chk("t4b_acc_during_wb", acc, 64'd0);
        wait_quiet();
        b_delay = 1;

        // 4c: same-cycle requests to one line: write first
        wr_push(32'h3000_0080, 32'h700);
        rd_push(32'h3000_0080, 32'h800);
        @(negedge clk); w_req = 1'b1; r_req = 1'b1; r_addr = 32'h3000_0080;
        #1;
        chk("t4c_w_rdy", w_rdy, 64'd1);
        chk("t4c_r_stall", r_rdy, 64'd0);
        @(negedge clk); w_req = 1'b0;
        rd_wait(acc, prev);
        chk("t4c_acc_after_b", acc, 64'd1);
        chk("t4c_first_idle", prev, 64'd0);
        wait_quiet();

        // 5: reset during refill beat 7 and write data phase
        w_hold = 1'b1;
        wr_push(32'h4000_0000, 32'h900);
        @(negedge clk); w_req = 1'b1;
        wr_wait();
        b0 = beats_rx;
        rd_push(32'h5000_0000, 32'hA00);
        @(negedge clk); r_req = 1'b1; r_addr = 32'h5000_0000;
        rd_wait(acc, prev);
        n = 0;
        #1;
        while (beats_rx - b0 < 7 && n < 200) begin
            @(negedge clk); #2;
            n++;
        end
        chk("t5_reach_beat7", beats_rx - b0, 64'd7);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        w_hold = 1'b0;
        exp_r.delete(); exp_rl.delete(); exp_w.delete(); exp_wl.delete();
        exp_ar.delete(); exp_aw.delete(); rb_q.delete();
        #1;
        chk("t5_r_data_valid", r_data_valid, 64'd0);
        chk("t5_r_last", r_last, 64'd0);
        chk("t5_arvalid", arvalid, 64'd0);
        chk("t5_rready", rready, 64'd0);
        chk("t5_awvalid", awvalid, 64'd0);
        chk("t5_wvalid", wvalid, 64'd0);
        chk("t5_wlast", wlast, 64'd0);
        chk("t5_bready", bready, 64'd0);
        chk("t5_wrt_finish", wrt_finish, 64'd1);
        b0 = beats_rx;
        rd_push(32'h5000_0080, 32'hB00);
        @(negedge clk); r_req = 1'b1; r_addr = 32'h5000_0080;
        rd_wait(acc, prev);
        wait_quiet();
        chk("t5_fresh_beats", beats_rx - b0, 64'd16);

`ifdef DCACHE_AXI_ERR_CAPTURE_EN
        // 6: sticky error capture
        chk("t6_err_clear", axi_err, 64'd0);
        bresp_err = 1'b1;
        wr_push(32'h6000_0000, 32'hC00);
        @(negedge clk); w_req = 1'b1;
        wr_wait();
        wait_quiet();
        bresp_err = 1'b0;
        inj_rlast = 1'b1;
        rd_push(32'h6000_0040, 32'hD00);
        @(negedge clk); r_req = 1'b1; r_addr = 32'h6000_0040;
        rd_wait(acc, prev);
        wait_quiet();
        inj_rlast = 1'b0;
        chk("t6_err", axi_err, 64'h6);
        repeat (5) @(negedge clk);
        #1;
        chk("t6_err_hold", axi_err, 64'h6);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        chk("t6_err_rst", axi_err, 64'd0);
`endif

        chk("queues_empty", exp_r.size() + exp_w.size() + exp_ar.size() + exp_aw.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
